// File: rtl/branch_update_queue.sv
// In-order retirement queue for predicted conditional branches: tracks each prediction
// until it resolves, then retires in program order into the predictor's update port.
module branch_update_queue #(
  parameter int DEPTH     = 8,
  parameter int GHR_WIDTH = 13,
  parameter int TAG_W     = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alloc_valid,
  output logic                 alloc_ready,
  input  logic [31:0]          alloc_pc,
  input  logic [GHR_WIDTH-1:0] alloc_ghr,
  input  logic                 alloc_pred,
  output logic [TAG_W-1:0]     alloc_tag,
  input  logic                 resolve_valid,
  input  logic [TAG_W-1:0]     resolve_tag,
  input  logic                 resolve_taken,
  output logic                 update_en,
  output logic [31:0]          update_pc,
  output logic [GHR_WIDTH-1:0] update_ghr_val,
  output logic                 actual_taken,
  output logic                 mispredict,
  output logic [GHR_WIDTH-1:0] recover_ghr
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]     valid_reg;
  logic [DEPTH-1:0]     resolved_reg;
  logic [DEPTH-1:0]     pred_mem;
  logic [DEPTH-1:0]     taken_mem;
  logic [31:0]          pc_mem  [DEPTH];
  logic [GHR_WIDTH-1:0] ghr_mem [DEPTH];

  logic [TAG_W-1:0] head_reg;
  logic [TAG_W-1:0] tail_reg;
  logic [CNT_W-1:0] count_reg;

  logic do_alloc;
  logic do_resolve;
  logic retire;
  logic retire_mp;

  assign retire      = valid_reg[head_reg] && resolved_reg[head_reg];
  assign retire_mp   = retire && (taken_mem[head_reg] != pred_mem[head_reg]);
  assign alloc_ready = (count_reg != CNT_W'(DEPTH)) && !retire_mp;
  assign alloc_tag   = tail_reg;
  assign do_alloc    = alloc_valid && alloc_ready;
  // A flushing retirement discards any resolve arriving in the same cycle.
  assign do_resolve  = resolve_valid && valid_reg[resolve_tag] && !retire_mp;

  // Per-entry status bits; later assignments take priority (alloc over resolve,
  // retire clears valid last).
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_reg[gi]    <= 1'b0;
          resolved_reg[gi] <= 1'b0;
        end else if (retire_mp) begin
          valid_reg[gi]    <= 1'b0;
          resolved_reg[gi] <= 1'b0;
        end else begin
          if (do_resolve && (resolve_tag == TAG_W'(gi)))
            resolved_reg[gi] <= 1'b1;
          if (do_alloc && (tail_reg == TAG_W'(gi))) begin
            valid_reg[gi]    <= 1'b1;
            resolved_reg[gi] <= 1'b0;
          end
          if (retire && (head_reg == TAG_W'(gi)))
            valid_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  // Payload storage needs no reset: it is only read behind a set valid bit.
  always_ff @(posedge clk) begin
    if (do_alloc) begin
      pc_mem[tail_reg]   <= alloc_pc;
      ghr_mem[tail_reg]  <= alloc_ghr;
      pred_mem[tail_reg] <= alloc_pred;
    end
    if (do_resolve)
      taken_mem[resolve_tag] <= resolve_taken;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (retire)
        head_reg <= head_reg + TAG_W'(1);
      if (retire_mp) begin
        tail_reg  <= head_reg + TAG_W'(1);
        count_reg <= '0;
      end else begin
        if (do_alloc)
          tail_reg <= tail_reg + TAG_W'(1);
        if (do_alloc && !retire)
          count_reg <= count_reg + CNT_W'(1);
        else if (!do_alloc && retire)
          count_reg <= count_reg - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      update_en      <= 1'b0;
      mispredict     <= 1'b0;
      update_pc      <= '0;
      update_ghr_val <= '0;
      actual_taken   <= 1'b0;
      recover_ghr    <= '0;
    end else begin
      update_en  <= retire;
      mispredict <= retire_mp;
      if (retire) begin
        update_pc      <= pc_mem[head_reg];
        update_ghr_val <= ghr_mem[head_reg];
        actual_taken   <= taken_mem[head_reg];
        recover_ghr    <= {ghr_mem[head_reg][GHR_WIDTH-2:0], taken_mem[head_reg]};
      end
    end
  end

endmodule

// File: tb/tb_branch_update_queue.sv
// Directed bench for branch_update_queue: retire order, latency, full/flush behaviour
// and asynchronous reset, with a log of every update pulse.
module tb_branch_update_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alloc_valid = 1'b0;
  logic        alloc_ready;
  logic [31:0] alloc_pc = '0;
  logic [12:0] alloc_ghr = '0;
  logic        alloc_pred = 1'b0;
  logic [2:0]  alloc_tag;
  logic        resolve_valid = 1'b0;
  logic [2:0]  resolve_tag = '0;
  logic        resolve_taken = 1'b0;
  logic        update_en;
  logic [31:0] update_pc;
  logic [12:0] update_ghr_val;
  logic        actual_taken;
  logic        mispredict;
  logic [12:0] recover_ghr;

  branch_update_queue #(.DEPTH(8), .GHR_WIDTH(13)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_pc(alloc_pc),
    .alloc_ghr(alloc_ghr), .alloc_pred(alloc_pred), .alloc_tag(alloc_tag),
    .resolve_valid(resolve_valid), .resolve_tag(resolve_tag), .resolve_taken(resolve_taken),
    .update_en(update_en), .update_pc(update_pc), .update_ghr_val(update_ghr_val),
    .actual_taken(actual_taken), .mispredict(mispredict), .recover_ghr(recover_ghr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] pc;
    logic [12:0] ghr;
    logic        taken;
    logic        mp;
    logic [12:0] rec;
  } ev_t;
  ev_t evq[$];

  always @(negedge clk)
    if (rst_n && update_en)
      evq.push_back('{cyc, update_pc, update_ghr_val, actual_taken, mispredict, recover_ghr});

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    alloc_valid = 1'b0;
    resolve_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic do_alloc(input logic [31:0] pc, input logic [12:0] ghr, input logic pred,
                          input logic [2:0] exp_tag);
    alloc_valid = 1'b1;
    alloc_pc = pc;
    alloc_ghr = ghr;
    alloc_pred = pred;
    @(negedge clk);
    check_val("alloc_ready", 32'(alloc_ready), 32'd1);
    check_val("alloc_tag", 32'(alloc_tag), 32'(exp_tag));
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic do_resolve(input logic [2:0] tag, input logic taken, output int rc);
    resolve_valid = 1'b1;
    resolve_tag = tag;
    resolve_taken = taken;
    rc = cyc;
    tick();
    resolve_valid = 1'b0;
  endtask

  int rc, rc0, rc1;

  initial begin
    // ---- reset state and single retirement latency ----
    do_reset();
    @(negedge clk);
    check_val("rst_alloc_ready", 32'(alloc_ready), 32'd1);
    check_val("rst_alloc_tag", 32'(alloc_tag), 32'd0);
    check_val("rst_update_en", 32'(update_en), 32'd0);
    check_val("rst_mispredict", 32'(mispredict), 32'd0);
    check_val("rst_update_pc", update_pc, 32'd0);
    check_val("rst_recover_ghr", 32'(recover_ghr), 32'd0);
    tick();
    evq.delete();
    do_alloc(32'h1000, 13'h0A5, 1'b1, 3'd0);
    tick();
    do_resolve(3'd0, 1'b1, rc);
    repeat (5) tick();
    check_val("t1_pulses", 32'(evq.size()), 32'd1);
    if (evq.size() >= 1) begin
      check_val("t1_cycle", 32'(evq[0].cyc), 32'(rc + 2));
      check_val("t1_pc", evq[0].pc, 32'h1000);
      check_val("t1_ghr", 32'(evq[0].ghr), 32'h0A5);
      check_val("t1_taken", 32'(evq[0].taken), 32'd1);
      check_val("t1_mp", 32'(evq[0].mp), 32'd0);
    end

    // ---- fill to full, retire one, ready returns ----
    do_reset();
    evq.delete();
    for (int i = 0; i < 8; i++)
      do_alloc(32'h2000 + 32'(i * 4), 13'(i), 1'b0, 3'(i));
    @(negedge clk);
    check_val("full_ready", 32'(alloc_ready), 32'd0);
    check_val("full_tag", 32'(alloc_tag), 32'd0);
    tick();
    do_resolve(3'd0, 1'b0, rc);
    @(negedge clk);
    check_val("full_ready_retire_cycle", 32'(alloc_ready), 32'd0);
    tick();
    @(negedge clk);
    check_val("full_ready_after", 32'(alloc_ready), 32'd1);
    check_val("full_update_en", 32'(update_en), 32'd1);
    check_val("full_update_pc", update_pc, 32'h2000);
    tick();

    // ---- out-of-order resolve, in-order retire ----
    do_reset();
    evq.delete();
    for (int i = 0; i < 4; i++)
      do_alloc(32'h3000 + 32'(i * 4), 13'h10 + 13'(i), 1'b1, 3'(i));
    do_resolve(3'd3, 1'b1, rc);
    do_resolve(3'd1, 1'b1, rc);
    do_resolve(3'd2, 1'b1, rc);
    tick();
    do_resolve(3'd0, 1'b1, rc0);
    repeat (8) tick();
    check_val("ooo_pulses", 32'(evq.size()), 32'd4);
    for (int i = 0; i < 4 && i < evq.size(); i++) begin
      check_val($sformatf("ooo_pc%0d", i), evq[i].pc, 32'h3000 + 32'(i * 4));
      check_val($sformatf("ooo_cycle%0d", i), 32'(evq[i].cyc), 32'(rc0 + 2 + i));
    end

    // ---- mispredict flush ----
    do_reset();
    evq.delete();
    do_alloc(32'h4000, 13'h0100, 1'b1, 3'd0);
    do_alloc(32'h4004, 13'h1FFF, 1'b0, 3'd1);
    do_alloc(32'h4008, 13'h0200, 1'b1, 3'd2);
    do_alloc(32'h400C, 13'h0300, 1'b1, 3'd3);
    do_resolve(3'd0, 1'b1, rc0);
    do_resolve(3'd1, 1'b1, rc1);
    @(negedge clk);
    check_val("mp_ready_low", 32'(alloc_ready), 32'd0);
    tick();
    @(negedge clk);
    check_val("mp_pulse", 32'(mispredict), 32'd1);
    check_val("mp_recover", 32'(recover_ghr), 32'h1FFF);
    check_val("mp_ready_back", 32'(alloc_ready), 32'd1);
    check_val("mp_next_tag", 32'(alloc_tag), 32'd2);
    tick();
    do_resolve(3'd2, 1'b1, rc);
    do_resolve(3'd3, 1'b1, rc);
    repeat (5) tick();
    check_val("mp_pulses", 32'(evq.size()), 32'd2);
    if (evq.size() >= 2) begin
      check_val("mp_ev0_pc", evq[0].pc, 32'h4000);
      check_val("mp_ev0_mp", 32'(evq[0].mp), 32'd0);
      check_val("mp_ev0_cycle", 32'(evq[0].cyc), 32'(rc0 + 2));
      check_val("mp_ev1_pc", evq[1].pc, 32'h4004);
      check_val("mp_ev1_mp", 32'(evq[1].mp), 32'd1);
      check_val("mp_ev1_ghr", 32'(evq[1].ghr), 32'h1FFF);
      check_val("mp_ev1_cycle", 32'(evq[1].cyc), 32'(rc1 + 2));
    end
    do_alloc(32'h5000, 13'h0001, 1'b1, 3'd2);

    // ---- asynchronous reset with entries pending ----
    for (int i = 3; i < 7; i++)
      do_alloc(32'h5000 + 32'(i * 4), 13'(i), 1'b1, 3'(i));
    check_val("pre_rst_update_pc", update_pc, 32'h4004);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_update_pc", update_pc, 32'd0);
    check_val("arst_update_ghr", 32'(update_ghr_val), 32'd0);
    check_val("arst_recover", 32'(recover_ghr), 32'd0);
    check_val("arst_taken", 32'(actual_taken), 32'd0);
    check_val("arst_update_en", 32'(update_en), 32'd0);
    check_val("arst_alloc_tag", 32'(alloc_tag), 32'd0);
    check_val("arst_alloc_ready", 32'(alloc_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    evq.delete();
    for (int i = 2; i < 7; i++)
      do_resolve(3'(i), 1'b1, rc);
    repeat (5) tick();
    check_val("arst_no_pulses", 32'(evq.size()), 32'd0);
    do_alloc(32'h6000, 13'h0002, 1'b0, 3'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_update_queue.md
# branch_update_queue

In-order tracking queue for predicted conditional branches; the resolution-side counterpart of the gshare predictor. The front end allocates an entry per predicted branch, capturing PC, the GHR snapshot used for lookup, and the predicted direction. Execute units resolve entries out of order by tag. The queue retires entries in program order and drives the predictor's update port (`update_en`, `update_pc`, `update_ghr_val`, `actual_taken`). On a mispredicted retirement it also raises a flush with the corrected GHR.

## Interface
- `DEPTH`, 8, entry count; power of two, ≥2
- `GHR_WIDTH`, 13, GHR width; equals predictor `K`
- `TAG_W`, `$clog2(DEPTH)`, tag width (derived)

- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous, active-low reset
- `alloc_valid`  in  1  front end presents a predicted branch
- `alloc_ready`  out  1  allocation accepted this cycle
- `alloc_pc`  in  32  branch PC
- `alloc_ghr`  in  GHR_WIDTH  GHR value used for the prediction
- `alloc_pred`  in  1  predicted direction (1 = taken)
- `alloc_tag`  out  TAG_W  tag of the entry being allocated (tail index)
- `resolve_valid`  in  1  execute reports an outcome
- `resolve_tag`  in  TAG_W  entry being resolved
- `resolve_taken`  in  1  actual direction
- `update_en`  out  1  predictor update strobe (1-cycle pulse per retirement)
- `update_pc`  out  32  retired branch PC
- `update_ghr_val`  out  GHR_WIDTH  retired branch's GHR snapshot
- `actual_taken`  out  1  retired branch's resolved direction
- `mispredict`  out  1  1-cycle pulse when the retired branch was mispredicted
- `recover_ghr`  out  GHR_WIDTH  `{update_ghr_val[GHR_WIDTH-2:0], actual_taken}`; valid while `mispredict` is high

## Operation
- Storage:
  - Per entry: `valid`, `resolved`, `pc`, `ghr`, `pred`, `taken`.
  - Pointers: `head` and `tail`, each TAG_W bits, wrapping modulo DEPTH.
  - `count`: $clog2(DEPTH+1) bits.
- Allocate:
  - Allocation occurs when `alloc_valid && alloc_ready`.
  - Writes the entry at `tail` with `valid=1` and `resolved=0`, then increments `tail`.
  - `alloc_tag` = `tail`, combinational.
- `alloc_ready` = `(count != DEPTH) && !retire_mp`. It is combinational.
- Resolve:
  - When `resolve_valid` is high and `entry[resolve_tag].valid` is set, write `taken` and set `resolved=1`.
  - Resolve to an invalid entry is ignored.
  - Re-resolving an already resolved entry overwrites `taken`.
- Retire:
  - Retirement happens when `entry[head].valid && entry[head].resolved`; at most one entry per cycle.
  - On retire: clear `valid`, increment `head`, decrement `count`, and register the update outputs from the entry.
  - `retire_mp` = retire && (`taken != pred`).
- Flush:
  - On `retire_mp`, clear `valid` on all entries.
  - Set `tail` = `head` + 1 (the new head) and `count` = 0.
  - A resolve in the same cycle is discarded.
- Count: alloc and a non-mispredicted retire in the same cycle leave `count` unchanged. Alloc is legal when full only if the retire frees a slot; it is not, because `alloc_ready` uses the registered `count`.
- Predictor wiring: the predictor's own GHR is not repaired by this block. `recover_ghr` is for the front end.

## Timing
- Reset (`rst_n` low, asynchronous):
  - `head`, `tail` and `count` = 0; all `valid` = 0.
  - `update_en`, `mispredict`, `actual_taken` = 0; `update_pc` = 0; `update_ghr_val` and `recover_ghr` = 0.
  - `alloc_ready` = 1 and `alloc_tag` = 0 after reset.
- Reset mid-operation discards all entries. No update pulse is emitted.
- Latency:
  - Resolve in cycle t sets `resolved` at the t/t+1 edge.
  - A head entry retires in cycle t+1.
  - `update_en` and `mispredict` are high in cycle t+2.
- Back-to-back resolved entries retire one per cycle, so `update_en` can be high on consecutive cycles.
- An entry allocated in cycle t may be resolved from cycle t+1 onward.
- Simultaneous resolve of the head and alloc: both are applied.
- Mispredict: `alloc_ready` is low during the retire_mp cycle. The next allocation is accepted in the following cycle at tag = old `head` + 1.

## Test plan
- Reset, then 1 alloc (pc=0x1000, ghr=0x0A5, pred=1), resolve tag 0 taken=1 in cycle 5 -> `update_en` high only in cycle 7 with `update_pc`=0x1000, `update_ghr_val`=0x0A5, `actual_taken`=1, and `mispredict`=0.
- Fill 8 entries -> `alloc_ready`=0 and `alloc_tag`=0 (wrapped). Resolve tag 0 -> retires, and `alloc_ready` returns to 1 the cycle after retirement.
- Allocate tags 0–3, resolve in order 3, 1, 2, 0 -> four `update_en` pulses in tag order 0, 1, 2, 3, on consecutive cycles after tag 0 resolves.
- Allocate tags 0–3, tag 1 pred=0 resolved taken=1, ghr=0x1FFF -> retire tag 0, then tag 1 with `mispredict`=1 and `recover_ghr`=0x1FFF. Tags 2–3 are discarded (their later resolves are ignored, with no update pulse), and the next `alloc_tag`=2.
- Assert `rst_n` low with 5 entries pending -> all outputs 0 immediately; after release, `alloc_tag`=0 and no `update_en` occurs.
